pixel_stream_gen: RTL
=====================

# pixel_stream_gen

Frame source for the CNN pipeline. A host loads one signed 8-bit image into an internal pixel RAM, then pulses `start`. The block replays the image in raster order as a `valid`/`pixel` stream that drives the pipeline's `valid_in`/`pixel_in`. It also holds the frame dimensions stable for the pipeline's `img_width`/`img_height` inputs for the whole frame.

## Interface
- `MAX_PIXELS`, 1024: pixel RAM depth; largest legal width×height.
- `ADDR_W`, 10: RAM address width; must satisfy 2^ADDR_W ≥ MAX_PIXELS.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: host RAM write strobe.
- `wr_addr` in ADDR_W: host write address (raster index row*width+col).
- `wr_data` in 8 signed: host write pixel.
- `start` in 1: single-cycle request to stream one frame.
- `img_width` in 8: frame width, sampled on accepted `start`.
- `img_height` in 8: frame height, sampled on accepted `start`.
- `gap_cycles` in 4: idle cycles inserted after each pixel, sampled on accepted `start`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last pixel.
- `err` out 1: one-cycle pulse when `start` is rejected.
- `valid_out` out 1: pixel strobe; connects to the pipeline's `valid_in`.
- `pixel_out` out 8 signed: pixel; connects to the pipeline's `pixel_in`.
- `sof` out 1: high with the first pixel of the frame.
- `eol` out 1: high with the last pixel of each row.
- `frame_width` out 8: latched width, held until the next accepted `start`.
- `frame_height` out 8: latched height, held until the next accepted `start`.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - READ: RAM read issued.
  - EMIT: output registered.
  - GAP: counting idle cycles.
  - FIN: pulses `done`, then returns to IDLE.
- IDLE + `start`:
  - Rejected when width=0, height=0, or width×height > MAX_PIXELS. Rejection pulses `err` the next cycle and the FSM stays in IDLE.
  - Otherwise the block latches the dimensions and gap, clears the row, column and address counters, and enters READ.
- READ: issues a synchronous RAM read at the current address, then moves to EMIT.
- EMIT: drives `valid_out`=1 with the read data.
  - `sof`=1 when row=col=0.
  - `eol`=1 when col=width-1.
  - Advances col. On wrap, col returns to 0 and row increments.
  - After the last pixel, the next state is FIN.
  - Otherwise the next state is GAP if the latched gap > 0, else READ. The READ of the next pixel is pipelined so that back-to-back pixels appear on consecutive cycles.
- GAP: `valid_out`=0 for exactly the latched gap cycles, then moves to READ.
- `start` while `busy`=1: ignored; no `err`.
- `wr_en` while `busy`=1: ignored, so the frame data stays consistent.
- Writes with `wr_addr` ≥ MAX_PIXELS: dropped.
- Address arithmetic:
  - 16-bit product width×height.
  - ADDR_W-bit linear address counter, incremented per pixel, independent of the row/col counters.

## Timing
- Reset values: `busy`, `done`, `err`, `valid_out`, `sof`, `eol` = 0; `pixel_out`=0; `frame_width`=`frame_height`=0. The FSM resets to IDLE.
- RAM contents are not reset.
- `start` accepted at cycle T:
  - `busy`=1 from T+1.
  - Pixel k has `valid_out`=1 at cycle T+2+k·(G+1), where G is the latched gap.
- With N = width×height:
  - `done`=1 at cycle T+2+(N-1)·(G+1)+1.
  - `busy` falls in that same cycle.
  - A new `start` is accepted in that cycle or later.
- `frame_width`/`frame_height` update at T+1.
- `pixel_out` holds its last value while `valid_out`=0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). No `done` pulse is produced.

## Configuration
- `PIXEL_GAP_EN` defined: gap insertion behaves as described above.
- `PIXEL_GAP_EN` undefined:
  - `gap_cycles` is ignored and GAP is never entered.
  - Pixels stream on consecutive cycles, so pixel k is valid at T+2+k and N pixels take N cycles.
  - The gap counter logic is removed.

## Test plan
- 3×3 frame, RAM = 1..9, gap 0, `start` at T: `valid_out` at T+2..T+10 with `pixel_out` 1..9; `sof` at T+2; `eol` at T+4, T+7, T+10; `done` at T+11.
- 4×2 frame, gap 2 (`PIXEL_GAP_EN` defined): 8 valid pixels spaced 3 cycles apart, first at T+2; `done` at T+24.
- `start` with width 0, and separately with 40×40 (1600 > 1024): `err` pulse at T+1; `busy` stays 0; no `valid_out`.
- Second `start` and `wr_en` (addr 0, data -5) mid-frame: frame output unchanged; no `err`; RAM[0] still holds its original value after `done`.
- Assert `rst_n`=0 during pixel 4 of a 3×3 frame: all outputs 0 immediately. After release, a new 3×3 `start` streams the full frame from pixel 0, using the retained RAM data.
- Frame 8 wide with values -128 and 127 driving the pipeline top: `pixel_out` sign is preserved at the pipeline input, and `frame_width`=8 stays stable throughout.

Source files
------------

// File: rtl/pixel_stream_gen_if.sv
// Host-side bus of pixel_stream_gen: RAM write port, frame request and the pixel stream.
// The master modport is the host/pipeline side and the slave modport is the generator.
interface pixel_stream_gen_if #(
  parameter int ADDR_W = 10
);
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic signed [7:0]    wr_data;
  logic                 start;
  logic [7:0]           img_width;
  logic [7:0]           img_height;
  logic [3:0]           gap_cycles;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 valid_out;
  logic signed [7:0]    pixel_out;
  logic                 sof;
  logic                 eol;
  logic [7:0]           frame_width;
  logic [7:0]           frame_height;

  modport master (
    output wr_en, wr_addr, wr_data, start, img_width, img_height, gap_cycles,
    input  busy, done, err, valid_out, pixel_out, sof, eol, frame_width, frame_height
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, img_width, img_height, gap_cycles,
    output busy, done, err, valid_out, pixel_out, sof, eol, frame_width, frame_height
  );
endinterface

// File: rtl/pixel_stream_gen.sv
// Replays a host-loaded signed 8-bit image from pixel RAM as a raster-order valid/pixel stream.
// First pixel 2 cycles after an accepted start; no backpressure. Gap insertion under `PIXEL_GAP_EN.
module pixel_stream_gen #(
  parameter int MAX_PIXELS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_stream_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, EMIT, GAP, FIN} state_t;

  localparam logic [15:0] MAX_AREA = 16'(MAX_PIXELS);

  state_t            state, state_nx;
  logic signed [7:0] ram [MAX_PIXELS];
  logic signed [7:0] rd_q;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        w_q, h_q, row, col;
  logic              err_q;
  logic [15:0]       area;
  logic              can_start, start_ok, accept, reject;
  logic              last_col, last_pix, rd_en, busy_int;
`ifdef PIXEL_GAP_EN
  logic [3:0]        gap_q, gap_cnt;
`endif

  assign area      = {8'd0, bus.img_width} * {8'd0, bus.img_height};
  assign start_ok  = (bus.img_width != 8'd0) && (bus.img_height != 8'd0) && (area <= MAX_AREA);
  // FIN already has busy low, so a new frame may be requested in the done cycle.
  assign can_start = bus.start && ((state == IDLE) || (state == FIN));
  assign accept    = can_start && start_ok;
  assign reject    = can_start && !start_ok;
  assign last_col  = (col == w_q - 8'd1);
  assign last_pix  = last_col && (row == h_q - 8'd1);
  assign busy_int  = (state == READ) || (state == EMIT) || (state == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      IDLE, FIN: state_nx = accept ? READ : IDLE;
      READ: begin
        rd_en    = 1'b1;
        state_nx = EMIT;
      end
      EMIT: begin
        if (last_pix) begin
          state_nx = FIN;
        end else begin
`ifdef PIXEL_GAP_EN
          // The READ cycle itself is the final idle cycle, so GAP covers only gap-1 cycles.
          if (gap_q == 4'd0) begin
            rd_en    = 1'b1;
            state_nx = EMIT;
          end else if (gap_q == 4'd1) begin
            state_nx = READ;
          end else begin
            state_nx = GAP;
          end
`else
          rd_en    = 1'b1;
          state_nx = EMIT;
`endif
        end
      end
      GAP: begin
`ifdef PIXEL_GAP_EN
        state_nx = (gap_cnt == 4'd1) ? READ : GAP;
`else
        state_nx = READ;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= 8'd0;
      h_q   <= 8'd0;
      row   <= 8'd0;
      col   <= 8'd0;
      addr  <= '0;
      rd_q  <= 8'sd0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        w_q  <= bus.img_width;
        h_q  <= bus.img_height;
        row  <= 8'd0;
        col  <= 8'd0;
        addr <= '0;
      end
      // addr is the read pointer, independent of row/col.
      if (rd_en) begin
        rd_q <= ram[addr];
        addr <= addr + 1'b1;
      end
      if (state == EMIT) begin
        if (last_col) begin
          col <= 8'd0;
          row <= row + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

`ifdef PIXEL_GAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q   <= 4'd0;
      gap_cnt <= 4'd0;
    end else begin
      if (accept) gap_q <= bus.gap_cycles;
      if (state == EMIT)     gap_cnt <= gap_q - 4'd1;
      else if (state == GAP) gap_cnt <= gap_cnt - 4'd1;
    end
  end
`endif

  // Host writes are locked out during a frame so the replayed image stays consistent.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_int && (int'(bus.wr_addr) < MAX_PIXELS))
      ram[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.busy         = busy_int;
  assign bus.done         = (state == FIN);
  assign bus.err          = err_q;
  assign bus.valid_out    = (state == EMIT);
  assign bus.pixel_out    = rd_q;
  assign bus.sof          = (state == EMIT) && (row == 8'd0) && (col == 8'd0);
  assign bus.eol          = (state == EMIT) && last_col;
  assign bus.frame_width  = w_q;
  assign bus.frame_height = h_q;

endmodule
